// File: rtl/temporizador_descendente_pkg.sv
// Shared constants for the loadable down-counting timer.
// State and mode encodings are kept as plain localparams for compatibility with legacy blocks.
package temporizador_descendente_pkg;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] CUENTA = 1'b1;

    localparam logic [0:0] MODO_UNICO     = 1'b0;
    localparam logic [0:0] MODO_PERIODICO = 1'b1;

endpackage

// File: rtl/temporizador_descendente_if.sv
// Control/status bundle of the down-counting timer.
// The master side issues starts and qualifiers; the timer is the slave.
interface temporizador_descendente_if #(
    parameter int unsigned width_counter = 4
) ();

    logic                     enable;
    logic                     inicio_valid;
    logic                     inicio_ready;
    logic [width_counter-1:0] valor_inicio;
    logic                     modo;
    logic                     abortar;
    logic [width_counter-1:0] cuenta;
    logic                     fin_cuenta;
    logic                     ocupado;

    modport master (
        output enable,
        output inicio_valid,
        output valor_inicio,
        output modo,
        output abortar,
        input  inicio_ready,
        input  cuenta,
        input  fin_cuenta,
        input  ocupado
    );

    modport slave (
        input  enable,
        input  inicio_valid,
        input  valor_inicio,
        input  modo,
        input  abortar,
        output inicio_ready,
        output cuenta,
        output fin_cuenta,
        output ocupado
    );

endinterface

// File: rtl/temporizador_descendente.sv
// Loadable down-counting timer with one-shot and periodic (auto-reload) modes.
// In periodic mode the reload happens on the terminal-count cycle itself, so the period is N+1.
module temporizador_descendente
    import temporizador_descendente_pkg::*;
#(
    parameter int unsigned width_counter = 4
) (
    input logic                       clock,
    input logic                       reset,
    temporizador_descendente_if.slave bus
);

    localparam logic [width_counter-1:0] Uno = {{(width_counter-1){1'b0}}, 1'b1};

    logic [0:0]               estado_q, estado_d;
    logic [width_counter-1:0] cuenta_q, cuenta_d;
    logic [width_counter-1:0] recarga_q, recarga_d;
    logic                     modo_q, modo_d;
    logic                     en_cero;

    assign en_cero = (cuenta_q == '0);

    always_comb begin
        estado_d  = estado_q;
        cuenta_d  = cuenta_q;
        recarga_d = recarga_q;
        modo_d    = modo_q;
        case (estado_q)
            IDLE: begin
                // abortar is deliberately not looked at here: a start beside it wins
                if (bus.inicio_valid) begin
                    estado_d  = CUENTA;
                    cuenta_d  = bus.valor_inicio;
                    recarga_d = bus.valor_inicio;
                    modo_d    = bus.modo;
                end
            end
            CUENTA: begin
                if (bus.abortar) begin
                    estado_d = IDLE;
                    cuenta_d = '0;
                end else if (bus.enable) begin
                    if (!en_cero) begin
                        cuenta_d = cuenta_q - Uno;
                    end else if (modo_q == MODO_PERIODICO) begin
                        cuenta_d = recarga_q;
                    end else begin
                        estado_d = IDLE;
                    end
                end
            end
            default: begin
                estado_d = IDLE;
                cuenta_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q  <= IDLE;
            cuenta_q  <= '0;
            recarga_q <= '0;
            modo_q    <= MODO_UNICO;
        end else begin
            estado_q  <= estado_d;
            cuenta_q  <= cuenta_d;
            recarga_q <= recarga_d;
            modo_q    <= modo_d;
        end
    end

    assign bus.inicio_ready = (estado_q == IDLE);
    assign bus.ocupado      = (estado_q == CUENTA);
    assign bus.cuenta       = cuenta_q;
    assign bus.fin_cuenta   = (estado_q == CUENTA) && en_cero && bus.enable && !bus.abortar;

endmodule

// File: tb/tb_temporizador_descendente.sv
// Scoreboard bench for temporizador_descendente: directed scenarios plus random traffic,
// checked against a phase-based model (count = N - enabled cycles since accept, mod N+1).
module tb_temporizador_descendente;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic [W-1:0] cuenta;
        logic         fin;
        logic         ocupado;
        logic         ready;
    } exp_t;

    logic clock;
    logic reset;
    temporizador_descendente_if #(.width_counter(W)) bus ();

    temporizador_descendente #(.width_counter(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model state
    bit m_active = 0;
    bit m_per    = 0;
    int m_n      = 0;
    int m_steps  = 0;

    function automatic bit m_terminal();
        return m_active && ((m_steps % (m_n + 1)) == m_n);
    endfunction

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, expv);
        end
    endtask

    // Monitor: every falling edge the DUT presents one cycle of outputs
    always @(negedge clock) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("cuenta", int'(bus.cuenta), int'(e.cuenta));
            check("fin_cuenta", int'(bus.fin_cuenta), int'(e.fin));
            check("ocupado", int'(bus.ocupado), int'(e.ocupado));
            check("inicio_ready", int'(bus.inicio_ready), int'(e.ready));
        end
    end

    task automatic step(input logic rst, input logic en, input logic iv,
                        input logic [W-1:0] val, input logic md, input logic ab);
        exp_t e;
        @(posedge clock);
        // Advance model with the inputs that were present at this edge
        if (!reset) begin
            m_active = 0;
            m_steps  = 0;
        end else if (m_active) begin
            if (bus.abortar) begin
                m_active = 0;
            end else if (bus.enable) begin
                if (m_terminal() && !m_per) m_active = 0;
                else m_steps++;
            end
        end else if (bus.inicio_valid) begin
            m_active = 1;
            m_n      = int'(bus.valor_inicio);
            m_per    = bus.modo;
            m_steps  = 0;
        end
        #1;
        reset            = rst;
        bus.enable       = en;
        bus.inicio_valid = iv;
        bus.valor_inicio = val;
        bus.modo         = md;
        bus.abortar      = ab;
        if (!rst) begin
            m_active = 0;
            m_steps  = 0;
        end
        e.cuenta  = m_active ? W'(m_n - (m_steps % (m_n + 1))) : '0;
        e.fin     = m_terminal() && en && !ab;
        e.ocupado = m_active;
        e.ready   = !m_active;
        sb_q.push_back(e);
    endtask

    initial begin
        reset            = 1'b0;
        bus.enable       = 1'b0;
        bus.inicio_valid = 1'b0;
        bus.valor_inicio = '0;
        bus.modo         = 1'b0;
        bus.abortar      = 1'b0;

        // Reset values, then idle with no start
        step(0, 0, 0, 4'd0, 0, 0);
        step(0, 1, 1, 4'd7, 1, 0);
        repeat (3) step(1, 1, 0, 4'd0, 0, 0);

        // One-shot N=3
        step(1, 0, 1, 4'd3, 0, 0);
        repeat (6) step(1, 1, 0, 4'd0, 0, 0);

        // Periodic N=2 with ignored start pulses
        step(1, 1, 1, 4'd2, 1, 0);
        for (int i = 0; i < 9; i++) step(1, 1, logic'(i % 2), 4'(i), 0, 0);
        step(1, 1, 0, 4'd0, 0, 1);
        step(1, 1, 0, 4'd0, 0, 0);

        // One-shot N=4, enable alternating
        step(1, 1, 1, 4'd4, 0, 0);
        for (int i = 0; i < 12; i++) step(1, logic'(i % 2 == 0), 0, 4'd0, 0, 0);

        // Periodic N=1: abort on the terminal cycle, then abort beside a start in IDLE
        step(1, 1, 1, 4'd1, 1, 0);
        step(1, 1, 0, 4'd0, 0, 0);
        step(1, 1, 0, 4'd0, 0, 1);
        step(1, 1, 1, 4'd5, 0, 1);
        repeat (3) step(1, 1, 0, 4'd0, 0, 0);
        step(1, 1, 0, 4'd0, 0, 1);

        // One-shot N=9 interrupted by reset at cuenta=5, then N=15 full run
        step(1, 1, 1, 4'd9, 0, 0);
        repeat (4) step(1, 1, 0, 4'd0, 0, 0);
        step(0, 1, 0, 4'd0, 0, 0);
        step(1, 1, 0, 4'd0, 0, 0);
        step(1, 1, 1, 4'd15, 0, 0);
        repeat (18) step(1, 1, 0, 4'd0, 0, 0);

        // Periodic N=0 and one-shot N=0
        step(1, 1, 1, 4'd0, 1, 0);
        repeat (4) step(1, logic'($urandom_range(0, 1)), 0, 4'd0, 0, 0);
        step(1, 1, 0, 4'd0, 0, 1);
        step(1, 0, 1, 4'd0, 0, 0);
        repeat (3) step(1, 1, 0, 4'd0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [W-1:0] v;
            int           r;
            r = $urandom_range(0, 9);
            v = (r == 0) ? '0 : (r == 1) ? '1 : W'($urandom);
            step(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 2) == 0), v, logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 19) == 0));
        end

        // Let the monitor drain, bounded
        for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(posedge clock);
        @(posedge clock);
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/temporizador_descendente.md
Name: temporizador_descendente

Overview:
Loadable down-counting timer: the counting-down counterpart of the team's variable-modulus up-counter. A start value N is accepted over a valid/ready handshake. The block counts N down to 0 on enabled cycles and flags terminal count. One-shot or periodic (auto-reload) operation; periodic mode yields one fin_cuenta every N+1 enabled cycles, the same period as the up-counter loaded with N.

Parameters:
width_counter, 4, width of start value and count register

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
enable  input  1  count qualifier; counter only moves on cycles with enable=1
inicio_valid  input  1  start request; valor_inicio and modo valid with it
inicio_ready  output  1  block can accept a start (high only in IDLE)
valor_inicio  input  width_counter  start/reload value N
modo  input  1  0 = one-shot, 1 = periodic (auto-reload)
abortar  input  1  synchronous stop request
cuenta  output  width_counter  current count value
fin_cuenta  output  1  terminal-count flag
ocupado  output  1  high while counting

Behaviour:
- Two states: IDLE, CUENTA. State register and cuenta use async active-low reset.
- Reset values: state IDLE, cuenta=0, internal reload register=0, modo latch=0, fin_cuenta=0, ocupado=0, inicio_ready=1.
- inicio_ready = (state==IDLE), combinational. ocupado = (state==CUENTA), combinational.
- Accept condition: inicio_valid && inicio_ready at a rising edge.
- On accept: cuenta<=valor_inicio, reload register<=valor_inicio, modo latched, state<=CUENTA.
- enable is not required at the accept edge.
- inicio_valid while in CUENTA is ignored; no queuing.
- In CUENTA with enable=1, abortar=0, cuenta!=0: cuenta<=cuenta-1.
- enable=0: all registers hold, fin_cuenta=0.
- Terminal count: fin_cuenta = (state==CUENTA) && (cuenta==0) && enable && !abortar. It is combinational, with no extra latency, and high for exactly one enabled cycle per period.
- At terminal count, one-shot (latched modo=0): state<=IDLE, cuenta stays 0, inicio_ready rises the next cycle.
- At terminal count, periodic (latched modo=1): cuenta<=reload register and state stays CUENTA. There is no dead cycle, so the period is exactly N+1 enabled cycles.
- N=0, one-shot: fin_cuenta on the first enabled cycle after accept, then IDLE.
- N=0, periodic: fin_cuenta on every enabled cycle.
- N=2**width_counter-1 is legal. cuenta never wraps below 0.
- abortar in CUENTA has highest priority, independent of enable: state<=IDLE, cuenta<=0. fin_cuenta is suppressed that cycle, even if cuenta==0.
- abortar in IDLE is ignored. A start accepted in the same cycle as abortar is honoured.
- Changing modo or valor_inicio mid-count has no effect; only the values latched at accept are used.
- Reset asserted mid-count: immediate (async) return to reset values. Counting resumes only after a new accept once reset is released.

Decomposition:
- Shared package/include holds:
  - state encodings: IDLE=1'b0, CUENTA=1'b1
  - mode constants: MODO_UNICO=1'b0, MODO_PERIODICO=1'b1
- Single flat module. No sub-module is natural: the down-counter, reload register and 2-state FSM are too tightly coupled to split.

Test Plan:
- Reset with width_counter=4 -> cuenta=0, fin_cuenta=0, ocupado=0, inicio_ready=1; inicio_valid held low leaves state unchanged.
- One-shot N=3, enable=1 continuously -> cuenta 3,2,1,0; fin_cuenta high only on the cuenta=0 cycle (4th cycle after accept); then IDLE, inicio_ready=1, cuenta=0.
- Periodic N=2, enable=1 -> cuenta 2,1,0,2,1,0,...; fin_cuenta every 3rd cycle over 9 cycles (3 pulses); inicio_valid pulses during the run are ignored, inicio_ready stays 0.
- One-shot N=4, enable alternating 1/0 -> cuenta holds on enable=0 cycles; fin_cuenta high only on the enabled cycle with cuenta=0 (after 5 enabled cycles).
- Periodic N=1: abortar asserted on the cycle cuenta=0 with enable=1 -> fin_cuenta stays 0; next cycle IDLE, cuenta=0, inicio_ready=1. Then abortar and a start (N=5) in the same IDLE cycle -> start accepted, cuenta=5.
- One-shot N=9: reset pulsed low when cuenta=5 -> all outputs at reset values immediately; after release, a new start N=15 counts 15 down to 0 with fin_cuenta after 16 enabled cycles.
